nibble_loader: RTL

- Upstream input stage of the 64-bit register: collects sixteen 4-bit nibbles, MSB-first, from board switches and keypad logic.
- When a full word is assembled, presents it on `data` with a one-cycle `E` strobe, so it connects directly to the register's `data` and `E` inputs.
- Sequences each load through a small FSM, with start, abort and busy control for the user-interface logic.

---
 rtl/nibble_loader_pkg.sv | 16 +
 rtl/nibble_loader_shreg.sv | 23 ++
 rtl/nibble_loader.sv | 103 ++++++++++
 3 files changed

// File: rtl/nibble_loader_pkg.sv
// Shared constants and state encoding for the nibble loader and the 64-bit
// register it feeds.
package nibble_loader_pkg;

   localparam int P_DATA = 64;
   localparam int P_NIB  = 4;
   localparam int N      = P_DATA / P_NIB;
   localparam int CNT_W  = $clog2(N);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EMIT = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_loader_shreg.sv
// Shift-in register: new nibbles enter at the LSB end, so the first nibble
// of a word ends up in the top slot once the word is complete.
module nib_shreg #(
   parameter int W  = 64,
   parameter int NW = 4
) (
   input  logic          clk,
   input  logic          R,
   input  logic          clr,
   input  logic          en,
   input  logic [NW-1:0] nib,
   output logic [W-1:0]  sr
);

   always_ff @(posedge clk) begin
      if (!R || clr) begin
         sr <= '0;
      end else if (en) begin
         sr <= {sr[W-NW-1:0], nib};
      end
   end

endmodule

// File: rtl/nibble_loader.sv
// Assembles P_DATA/P_NIB nibbles, MSB-first, into one word and presents it
// with a single-cycle E strobe; start/abort/busy handshake for the UI logic.
module nibble_loader
   import nibble_loader_pkg::*;
#(
   parameter int P_DATA = nibble_loader_pkg::P_DATA,
   parameter int P_NIB  = nibble_loader_pkg::P_NIB
) (
   input  logic                             clk,
   input  logic                             R,
   input  logic                             start,
   input  logic                             abort,
   input  logic [P_NIB-1:0]                 nib,
   input  logic                             nib_vld,
   output logic [P_DATA-1:0]                data,
   output logic                             E,
   output logic                             busy,
   output logic [$clog2(P_DATA/P_NIB)-1:0]  cnt
);

   localparam int NN = P_DATA / P_NIB;
   localparam int CW = $clog2(NN);
   localparam logic [CW-1:0] CNT_LAST = CW'(NN - 1);

   if (P_DATA % P_NIB != 0) begin : g_bad_width
      $error("nibble_loader: P_DATA must be a multiple of P_NIB");
   end

   state_t            state;
   logic [P_DATA-1:0] sr;
   logic              sr_clr;
   logic              sr_en;
   logic              take_start;
   logic              take_nib;

   // abort outranks both start and nib_vld, so it gates every shift/clear path
   assign take_start = (state == ST_IDLE) && start && !abort;
   assign take_nib   = (state == ST_LOAD) && nib_vld && !abort;
   assign sr_clr     = take_start || ((state == ST_LOAD) && abort);
   assign sr_en      = take_nib;

   nib_shreg #(
      .W  (P_DATA),
      .NW (P_NIB)
   ) u_shreg (
      .clk (clk),
      .R   (R),
      .clr (sr_clr),
      .en  (sr_en),
      .nib (nib),
      .sr  (sr)
   );

   always_ff @(posedge clk) begin
      if (!R) begin
         state <= ST_IDLE;
         data  <= '0;
         E     <= 1'b0;
         busy  <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               E <= 1'b0;
               if (take_start) begin
                  state <= ST_LOAD;
                  busy  <= 1'b1;
                  cnt   <= '0;
               end
            end
            ST_LOAD: begin
               if (abort) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else if (nib_vld) begin
                  if (cnt == CNT_LAST) begin
                     // last nibble bypasses sr straight into the output word
                     data  <= {sr[P_DATA-P_NIB-1:0], nib};
                     E     <= 1'b1;
                     state <= ST_EMIT;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            ST_EMIT: begin
               E     <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               E     <= 1'b0;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
